// File: rtl/apb_ecc_csr_bank.sv
// APB3 register bank in front of the ECC core: config registers, core launch,
// result capture, write-while-busy wait-states with bounded timeout and PSLVERR.
module apb_ecc_csr_bank #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned WAIT_MAX        = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic                       core_start,
    output logic [1:0]                 core_ctrl,
    output logic [DATA_WIDTH-1:0]      core_data_in,
    output logic [1:0]                 core_cw_width,
    output logic [DATA_WIDTH-1:0]      core_noise,
    input  logic                       core_done,
    input  logic [DATA_WIDTH-1:0]      core_data_out,
    input  logic [1:0]                 core_num_errors,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors
);

    localparam int unsigned SW = $clog2(WAIT_MAX + 1);

    logic [4:0]            addr;
    logic                  access, addr_bad, cfg_wr, status_wr;
    logic                  wait_st, timeout, commit, core_fire;
    logic                  unused_bits;

    logic [1:0]            ctrl_q, ctrl_d, cw_q, cw_d, nerr_q, nerr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d, noise_q, noise_d, dout_q, dout_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  start_q, start_d, opdone_q, opdone_d;
    logic [SW-1:0]         stall_q, stall_d;

    assign unused_bits = ^{PADDR, PWDATA};

    assign addr      = PADDR[4:0];
    assign access    = PSEL & PENABLE;
    assign addr_bad  = (addr > 5'h14) || (addr[1:0] != 2'b00) || (PWRITE && addr == 5'h14);
    assign cfg_wr    = access & PWRITE & ~addr_bad & (addr < 5'h10);
    assign status_wr = access & PWRITE & ~addr_bad & (addr == 5'h10);
    // The timeout fires on the WAIT_MAX-th ACCESS cycle of a stalled write.
    assign timeout   = cfg_wr & busy_q & (stall_q == SW'(WAIT_MAX - 1));
    assign wait_st   = cfg_wr & busy_q & ~timeout;
    assign commit    = cfg_wr & ~busy_q;
    assign core_fire = core_done & busy_q;

    assign PREADY  = ~wait_st;
    assign PSLVERR = access & (addr_bad | timeout);

    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE && !addr_bad) begin
            case (addr)
                5'h00:   PRDATA = AMBA_WORD'(ctrl_q);
                5'h04:   PRDATA = AMBA_WORD'(din_q);
                5'h08:   PRDATA = AMBA_WORD'(cw_q);
                5'h0C:   PRDATA = AMBA_WORD'(noise_q);
                5'h10:   PRDATA = AMBA_WORD'({nerr_q, busy_q, done_q});
                5'h14:   PRDATA = AMBA_WORD'(dout_q);
                default: PRDATA = '0;
            endcase
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        din_d    = din_q;
        cw_d     = cw_q;
        noise_d  = noise_q;
        busy_d   = busy_q;
        done_d   = done_q;
        dout_d   = dout_q;
        nerr_d   = nerr_q;
        start_d  = 1'b0;
        opdone_d = 1'b0;
        stall_d  = wait_st ? stall_q + SW'(1) : '0;

        if (commit) begin
            case (addr)
                5'h00: begin
                    ctrl_d  = PWDATA[1:0];
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
                5'h04:   din_d   = PWDATA[DATA_WIDTH-1:0];
                5'h08:   cw_d    = PWDATA[1:0];
                5'h0C:   noise_d = PWDATA[DATA_WIDTH-1:0];
                default: ;
            endcase
        end

        if (status_wr && PWDATA[0]) begin
            done_d = 1'b0;
        end

        // Completion overrides a coincident W1C so the done flag is never lost.
        if (core_fire) begin
            busy_d   = 1'b0;
            done_d   = 1'b1;
            dout_d   = core_data_out;
            nerr_d   = core_num_errors;
            opdone_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            din_q    <= '0;
            cw_q     <= '0;
            noise_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
            nerr_q   <= '0;
            start_q  <= 1'b0;
            opdone_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            din_q    <= din_d;
            cw_q     <= cw_d;
            noise_q  <= noise_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
            nerr_q   <= nerr_d;
            start_q  <= start_d;
            opdone_q <= opdone_d;
            stall_q  <= stall_d;
        end
    end

    assign core_start     = start_q;
    assign core_ctrl      = ctrl_q;
    assign core_data_in   = din_q;
    assign core_cw_width  = cw_q;
    assign core_noise     = noise_q;
    assign data_out       = dout_q;
    assign operation_done = opdone_q;
    assign num_of_errors  = nerr_q;

endmodule

// File: tb/tb_apb_ecc_csr_bank.sv
// Bench for apb_ecc_csr_bank: directed scenarios then random APB traffic
// compared against a register-level behavioural model.
module tb_apb_ecc_csr_bank;

    localparam int unsigned TB_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        core_start;
    logic [1:0]  core_ctrl, core_cw_width;
    logic [31:0] core_data_in, core_noise;
    logic        core_done;
    logic [31:0] core_data_out;
    logic [1:0]  core_num_errors;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg[4];
    logic        m_busy, m_done;
    logic [1:0]  m_nerr;
    logic [31:0] m_res;

    apb_ecc_csr_bank #(
        .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .WAIT_MAX(TB_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .core_start(core_start), .core_ctrl(core_ctrl),
        .core_data_in(core_data_in), .core_cw_width(core_cw_width),
        .core_noise(core_noise), .core_done(core_done), .core_data_out(core_data_out),
        .core_num_errors(core_num_errors), .data_out(data_out),
        .operation_done(operation_done), .num_of_errors(num_of_errors)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: registers as an array indexed by word address; core completes only when busy.
    function automatic logic [31:0] reg_mask(input int idx);
        return (idx == 0 || idx == 2) ? 32'h3 : 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_busy = 0; m_done = 0; m_nerr = '0; m_res = '0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d);
        m_reg[a >> 2] = d & reg_mask(int'(a >> 2));
        if (a == 5'h00) begin m_busy = 1; m_done = 0; end
    endtask

    task automatic model_fire();
        if (m_busy) begin
            m_busy = 0; m_done = 1; m_res = core_data_out; m_nerr = core_num_errors;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a < 5'h10) return m_reg[a >> 2];
        if (a == 5'h10) return {28'h0, m_nerr, m_busy, m_done};
        return m_res;
    endfunction

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, input int done_at,
                             output int waits, output logic err, output logic start);
        PADDR = {15'($urandom), a}; PWRITE = 1; PWDATA = d; PSEL = 1; PENABLE = 0;
        tick();
        PENABLE = 1; waits = 0; err = 0;
        for (int i = 0; i < 64; i++) begin
            core_done = (i == done_at);
            #1;
            if (PREADY) begin
                err = PSLVERR;
                tick();
                break;
            end
            waits++;
            tick();
        end
        start = core_start;
        core_done = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] data,
                            output logic err, output logic rdy);
        PADDR = {15'($urandom), a}; PWRITE = 0; PSEL = 1; PENABLE = 0;
        tick();
        PENABLE = 1;
        #1;
        data = PRDATA; err = PSLVERR; rdy = PREADY;
        tick();
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic pulse_done(output logic op);
        core_done = 1;
        tick();
        core_done = 0;
        op = operation_done;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_ctrl"},  32'(core_ctrl),     m_reg[0]);
        check_eq({tag, "_din"},   core_data_in,       m_reg[1]);
        check_eq({tag, "_cw"},    32'(core_cw_width), m_reg[2]);
        check_eq({tag, "_noise"}, core_noise,         m_reg[3]);
        check_eq({tag, "_dout"},  data_out,           m_res);
        check_eq({tag, "_nerr"},  32'(num_of_errors), 32'(m_nerr));
    endtask

    initial begin
        logic [31:0] rd, d;
        logic        e, r, s, op, fire;
        logic [4:0]  a;
        int          w, da;
        logic [4:0]  bad_addrs[6] = '{5'h18, 5'h1C, 5'h02, 5'h05, 5'h13, 5'h1F};

        rst = 1; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
        core_done = 0; core_data_out = '0; core_num_errors = '0;
        model_reset();
        repeat (2) tick();
        rst = 0;

        check_eq("rst_prdata", PRDATA, 32'h0);
        check_eq("rst_pslverr", 32'(PSLVERR), 32'h0);
        check_eq("rst_pready", 32'(PREADY), 32'h1);
        check_eq("rst_start", 32'(core_start), 32'h0);
        check_eq("rst_opdone", 32'(operation_done), 32'h0);
        check_outputs("rst");
        apb_read(5'h10, rd, e, r);
        check_eq("rst_status", rd, 32'h0);

        apb_write(5'h04, 32'hA5A5_0F0F, -1, w, e, s);
        check_eq("din_waits", 32'(w), 32'h0);
        check_eq("din_err", 32'(e), 32'h0);
        model_write(5'h04, 32'hA5A5_0F0F);
        apb_write(5'h08, 32'h2, -1, w, e, s);
        model_write(5'h08, 32'h2);
        apb_read(5'h04, rd, e, r);
        check_eq("din_rd", rd, 32'hA5A5_0F0F);
        check_eq("din_rd_rdy", 32'(r), 32'h1);
        apb_read(5'h08, rd, e, r);
        check_eq("cw_rd", rd, 32'h2);
        check_eq("cw_rd_err", 32'(e), 32'h0);

        apb_write(5'h00, 32'h1, -1, w, e, s);
        model_write(5'h00, 32'h1);
        check_eq("ctrl_start", 32'(s), 32'h1);
        tick();
        check_eq("ctrl_start_1cyc", 32'(core_start), 32'h0);
        apb_read(5'h10, rd, e, r);
        check_eq("status_busy", rd, 32'h2);
        core_data_out = 32'h1234; core_num_errors = 2'd1;
        pulse_done(op);
        model_fire();
        check_eq("opdone", 32'(op), 32'h1);
        tick();
        check_eq("opdone_1cyc", 32'(operation_done), 32'h0);
        apb_read(5'h10, rd, e, r);
        check_eq("status_done", rd, 32'h5);
        apb_read(5'h14, rd, e, r);
        check_eq("result", rd, 32'h1234);

        apb_write(5'h00, 32'h2, -1, w, e, s);
        model_write(5'h00, 32'h2);
        core_data_out = 32'h0BAD_F00D; core_num_errors = 2'd2;
        apb_write(5'h0C, 32'h0000_00FF, 2, w, e, s);
        model_fire();
        model_write(5'h0C, 32'h0000_00FF);
        check_eq("stall_waits", 32'(w), 32'h3);
        check_eq("stall_err", 32'(e), 32'h0);
        apb_read(5'h0C, rd, e, r);
        check_eq("stall_noise", rd, 32'h0000_00FF);

        apb_write(5'h00, 32'h0, -1, w, e, s);
        model_write(5'h00, 32'h0);
        apb_write(5'h0C, 32'hDEAD_BEEF, -1, w, e, s);
        check_eq("tmo_waits", 32'(w), 32'(TB_WAIT - 1));
        check_eq("tmo_err", 32'(e), 32'h1);
        apb_read(5'h0C, rd, e, r);
        check_eq("tmo_noise", rd, 32'h0000_00FF);
        pulse_done(op);
        model_fire();

        apb_read(5'h18, rd, e, r);
        check_eq("bad18_err", 32'(e), 32'h1);
        check_eq("bad18_data", rd, 32'h0);
        apb_read(5'h02, rd, e, r);
        check_eq("bad02_err", 32'(e), 32'h1);
        check_eq("bad02_data", rd, 32'h0);
        apb_write(5'h00, 32'h1, -1, w, e, s);
        model_write(5'h00, 32'h1);
        core_num_errors = 2'd2;
        apb_write(5'h10, 32'h1, 0, w, e, s);
        model_fire();
        apb_read(5'h10, rd, e, r);
        check_eq("w1c_vs_done", rd, 32'h9);

        apb_write(5'h00, 32'h3, -1, w, e, s);
        rst = 1; tick(); rst = 0;
        model_reset();
        pulse_done(op);
        check_eq("rst_late_opdone", 32'(op), 32'h0);
        apb_read(5'h10, rd, e, r);
        check_eq("rst_late_status", rd, 32'h0);
        check_outputs("rst_mid");

        for (int it = 0; it < 150; it++) begin
            core_data_out = $urandom; core_num_errors = 2'($urandom);
            case ($urandom_range(0, 5))
                0, 1: begin
                    a = 5'($urandom_range(0, 3) * 4); d = $urandom;
                    da = (m_busy && $urandom_range(0, 3) != 0) ? int'($urandom_range(0, 5)) : -1;
                    apb_write(a, d, da, w, e, s);
                    fire = 0;
                    if (!m_busy) begin
                        check_eq("r_wr_waits", 32'(w), 32'h0);
                        check_eq("r_wr_err", 32'(e), 32'h0);
                        model_write(a, d);
                        fire = (a == 5'h00);
                    end else if (da < 0) begin
                        check_eq("r_tmo_waits", 32'(w), 32'(TB_WAIT - 1));
                        check_eq("r_tmo_err", 32'(e), 32'h1);
                    end else begin
                        check_eq("r_stall_waits", 32'(w), 32'(da + 1));
                        check_eq("r_stall_err", 32'(e), 32'h0);
                        model_fire();
                        model_write(a, d);
                        fire = (a == 5'h00);
                    end
                    check_eq("r_start", 32'(s), 32'(fire));
                end
                2: begin
                    a = 5'($urandom_range(0, 5) * 4);
                    apb_read(a, rd, e, r);
                    check_eq("r_rd", rd, model_read(a));
                    check_eq("r_rd_err", 32'(e), 32'h0);
                    check_eq("r_rd_rdy", 32'(r), 32'h1);
                end
                3: begin
                    if ($urandom_range(0, 1) != 0) begin
                        apb_read(bad_addrs[$urandom_range(0, 5)], rd, e, r);
                        check_eq("r_bad_rd", rd, 32'h0);
                        check_eq("r_bad_rd_err", 32'(e), 32'h1);
                    end else begin
                        a = ($urandom_range(0, 2) == 0) ? 5'h14 : bad_addrs[$urandom_range(0, 5)];
                        apb_write(a, $urandom, -1, w, e, s);
                        check_eq("r_bad_wr_waits", 32'(w), 32'h0);
                        check_eq("r_bad_wr_err", 32'(e), 32'h1);
                    end
                end
                4: begin
                    d = $urandom;
                    da = (m_busy && $urandom_range(0, 1) != 0) ? 0 : -1;
                    fire = m_busy && (da == 0);
                    apb_write(5'h10, d, da, w, e, s);
                    check_eq("r_w1c_waits", 32'(w), 32'h0);
                    check_eq("r_w1c_err", 32'(e), 32'h0);
                    if (fire) model_fire();
                    else if (d[0]) m_done = 0;
                end
                default: begin
                    fire = m_busy;
                    pulse_done(op);
                    model_fire();
                    check_eq("r_opdone", 32'(op), 32'(fire));
                end
            endcase
            check_outputs("r");
        end

        apb_read(5'h10, rd, e, r);
        check_eq("final_status", rd, model_read(5'h10));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
